// File: rtl/ps2_command_sender.sv
// PS/2 host-to-device command transmitter.
// Inhibits the bus, issues a start bit, shifts one command byte out on the
// device-generated clock (LSB first, odd parity, stop), checks the device
// ACK and waits for the bus to go idle. Pins are open-drain: the outputs
// only ever request a pull-low, and the top level tri-states otherwise.
module ps2_command_sender #(
  parameter int unsigned INHIBIT_CYCLES = 6000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       send,
  input  logic [7:0] tx_byte,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_XMIT,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic             clk_meta, clk_sync, clk_prev;
  logic             dat_meta, dat_sync;
  logic             fe;
  logic [9:0]       shift;
  logic [3:0]       nbits;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;

  // Two-stage synchronizers for both pins plus the previous clock sample.
  // They reset to 1 (idle bus) so no falling edge is seen leaving reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= PS2_CLK;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= PS2_DAT;
      dat_sync <= dat_meta;
    end
  end

  // Device clock falling edge, one cycle wide.
  always_comb begin
    fe = clk_prev & ~clk_sync;
  end

  // Transmit sequencer with registered pin drives and status pulses.
  // The start bit stays on the data line through XMIT until the first
  // device falling edge replaces it with bit 0.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state             <= S_IDLE;
      ps2_clk_drive_low <= 1'b0;
      ps2_dat_drive_low <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      shift             <= '0;
      nbits             <= '0;
      inh_cnt           <= '0;
      to_cnt            <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      unique case (state)
        S_IDLE: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          busy              <= 1'b0;
          if (send) begin
            shift             <= {1'b1, ~^tx_byte, tx_byte};
            nbits             <= '0;
            inh_cnt           <= '0;
            busy              <= 1'b1;
            ps2_clk_drive_low <= 1'b1;
            state             <= S_INHIBIT;
          end
        end

        S_INHIBIT: begin
          if (inh_cnt == INH_LAST) begin
            ps2_dat_drive_low <= 1'b1;
            state             <= S_START;
          end else begin
            inh_cnt <= inh_cnt + 1'b1;
          end
        end

        S_START: begin
          ps2_clk_drive_low <= 1'b0;
          to_cnt            <= '0;
          state             <= S_XMIT;
        end

        S_XMIT: begin
          if (fe) begin
            ps2_dat_drive_low <= ~shift[nbits];
            nbits             <= nbits + 1'b1;
            to_cnt            <= '0;
            if (nbits == 4'd9) begin
              state <= S_ACK;
            end
          end else if (to_cnt == TO_LAST) begin
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            busy              <= 1'b0;
            error             <= 1'b1;
            state             <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_ACK: begin
          if (fe) begin
            to_cnt <= '0;
            if (dat_sync) begin
              ps2_clk_drive_low <= 1'b0;
              ps2_dat_drive_low <= 1'b0;
              busy              <= 1'b0;
              error             <= 1'b1;
              state             <= S_IDLE;
            end else begin
              state <= S_WAIT_IDLE;
            end
          end else if (to_cnt == TO_LAST) begin
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            busy              <= 1'b0;
            error             <= 1'b1;
            state             <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_WAIT_IDLE: begin
          if (clk_sync && dat_sync) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else if (to_cnt == TO_LAST) begin
            ps2_clk_drive_low <= 1'b0;
            ps2_dat_drive_low <= 1'b0;
            busy              <= 1'b0;
            error             <= 1'b1;
            state             <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: begin
          ps2_clk_drive_low <= 1'b0;
          ps2_dat_drive_low <= 1'b0;
          busy              <= 1'b0;
          state             <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_sender.sv
// Bench for ps2_command_sender: an open-drain PS/2 device model clocks the
// frame out, samples each bit on the rising clock and answers with an ACK.
module tb_ps2_command_sender;

  localparam int INH     = 20;
  localparam int TIMEOUT = 2000;
  localparam int HALF    = 40;

  logic       clk;
  logic       resetn;
  logic       send;
  logic [7:0] tx_byte;
  logic       PS2_CLK;
  logic       PS2_DAT;
  logic       ps2_clk_drive_low;
  logic       ps2_dat_drive_low;
  logic       busy;
  logic       done;
  logic       error;

  logic dev_clk;
  logic dev_dat;

  // Wired-AND bus: either side may pull a line low.
  assign PS2_CLK = dev_clk & ~ps2_clk_drive_low;
  assign PS2_DAT = dev_dat & ~ps2_dat_drive_low;

  ps2_command_sender #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .send             (send),
    .tx_byte          (tx_byte),
    .PS2_CLK          (PS2_CLK),
    .PS2_DAT          (PS2_DAT),
    .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_dat_drive_low(ps2_dat_drive_low),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Pulse monitor: counts pulses and flags overlap, width and busy problems.
  int  done_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0, busy_on_done = 0;
  logic done_q = 1'b0, err_q = 1'b0;
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (error === 1'b1) err_cnt++;
    if (done === 1'b1 && error === 1'b1) both_cnt++;
    if ((done === 1'b1 && done_q) || (error === 1'b1 && err_q)) wide_cnt++;
    if (done === 1'b1 && busy !== 1'b0) busy_on_done++;
    done_q = (done === 1'b1);
    err_q  = (error === 1'b1);
  end

  // Reference frame as the device must observe it: data LSB first, then
  // odd parity counted from the number of ones, then a 1 stop bit.
  function automatic logic [9:0] frame_of(input logic [7:0] b);
    int ones;
    logic [9:0] f;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
    for (int i = 0; i < 8; i++) f[i] = ((b >> i) & 1) != 0;
    f[8] = (ones % 2 == 0);
    f[9] = 1'b1;
    return f;
  endfunction

  // One complete host transfer driven against the device model.
  // outcome: 0 nothing, 1 done, 2 error, 3 inconsistent.
  task automatic run_transfer(input logic [7:0] b, input bit ack, input int stop_after,
                              input int poke_k, output logic [9:0] sampled, output bit seq_ok,
                              output int outcome, output int to_lat);
    int n, d0, e0;
    seq_ok  = 1'b1;
    sampled = '0;
    to_lat  = -1;
    outcome = 0;
    d0 = done_cnt;
    e0 = err_cnt;
    tx_byte = b;
    send    = 1'b1;
    @(negedge clk);
    send    = 1'b0;
    tx_byte = 8'($urandom);
    for (int i = 0; i < INH; i++) begin
      if (!(ps2_clk_drive_low === 1'b1 && ps2_dat_drive_low === 1'b0 && busy === 1'b1)) seq_ok = 1'b0;
      @(negedge clk);
    end
    if (!(ps2_clk_drive_low === 1'b1 && ps2_dat_drive_low === 1'b1 && busy === 1'b1)) seq_ok = 1'b0;
    @(negedge clk);
    if (!(ps2_clk_drive_low === 1'b0 && busy === 1'b1)) seq_ok = 1'b0;

    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        repeat (HALF / 2) @(negedge clk);
        dev_dat = ack;
        repeat (HALF - HALF / 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b0;
      if (k == stop_after) begin
        n = 0;
        while (n < TIMEOUT + 100) begin
          @(negedge clk);
          n++;
          if (error === 1'b1) break;
          if (n == HALF) dev_clk = 1'b1;
        end
        dev_clk = 1'b1;
        if (error === 1'b1) to_lat = n;
        break;
      end
      if (k == poke_k) begin
        send    = 1'b1;
        tx_byte = 8'hFF;
        @(negedge clk);
        send = 1'b0;
        repeat (HALF - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b1;
      if (k <= 10) sampled[k-1] = PS2_DAT;
    end
    if (stop_after == 0) repeat (10) @(negedge clk);
    dev_dat = 1'b1;

    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < TIMEOUT + 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (done_cnt - d0 == 1 && err_cnt == e0) outcome = 1;
    else if (err_cnt - e0 == 1 && done_cnt == d0) outcome = 2;
    else if (done_cnt != d0 || err_cnt != e0) outcome = 3;
  endtask

  typedef struct {
    logic [7:0] b;
    bit         ack;
    int         stop_after;
    int         poke_k;
    int         exp_outcome;
    bit         exp_parity;
  } vec_t;

  vec_t       vecs[6];
  logic [9:0] sampled;
  bit         seq_ok;
  int         outcome, to_lat, d0, e0;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hED, 1'b0, 0, 0, 1, 1'b1};
    vecs[1] = '{8'hF4, 1'b0, 0, 0, 1, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 0, 0, 1, 1'b1};
    vecs[3] = '{8'hA5, 1'b1, 0, 0, 2, 1'b1};
    vecs[4] = '{8'h3C, 1'b0, 4, 0, 2, 1'b1};
    vecs[5] = '{8'hED, 1'b0, 0, 3, 1, 1'b1};

    resetn  = 1'b0;
    send    = 1'b0;
    tx_byte = 8'h00;
    dev_clk = 1'b1;
    dev_dat = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_clk_drive", ps2_clk_drive_low, 0);
    chk("reset_dat_drive", ps2_dat_drive_low, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_error", error, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      run_transfer(vecs[v].b, vecs[v].ack, vecs[v].stop_after, vecs[v].poke_k,
                   sampled, seq_ok, outcome, to_lat);
      chk($sformatf("v%0d_inhibit_start_seq", v), 32'(seq_ok), 1);
      chk($sformatf("v%0d_outcome", v), outcome, vecs[v].exp_outcome);
      if (vecs[v].stop_after == 0) begin
        chk($sformatf("v%0d_frame", v), 32'(sampled), 32'(frame_of(vecs[v].b)));
        chk($sformatf("v%0d_parity", v), 32'(sampled[8]), 32'(vecs[v].exp_parity));
      end else begin
        chk($sformatf("v%0d_timeout_latency", v), to_lat, TIMEOUT + 3);
      end
      chk($sformatf("v%0d_released", v), {busy, ps2_clk_drive_low, ps2_dat_drive_low}, 0);
      repeat (5) @(negedge clk);
      chk($sformatf("v%0d_stays_idle", v), {busy, ps2_clk_drive_low, ps2_dat_drive_low}, 0);
    end

    // Reset pulse in the middle of INHIBIT, then a fresh 0xFF transfer.
    d0 = done_cnt;
    e0 = err_cnt;
    tx_byte = 8'hED;
    send    = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (5) @(negedge clk);
    chk("inhibit_before_reset", ps2_clk_drive_low, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_released", {busy, ps2_clk_drive_low, ps2_dat_drive_low}, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("midreset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    run_transfer(8'hFF, 1'b0, 0, 0, sampled, seq_ok, outcome, to_lat);
    chk("ff_seq", 32'(seq_ok), 1);
    chk("ff_frame", 32'(sampled), 32'h3FF);
    chk("ff_outcome", outcome, 1);

    // Back-to-back random transfers against the reference frame model.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] b;
      bit         ack;
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) == 0);
      run_transfer(b, ack, 0, 0, sampled, seq_ok, outcome, to_lat);
      chk($sformatf("r%0d_seq b=%0h", r, b), 32'(seq_ok), 1);
      chk($sformatf("r%0d_frame b=%0h", r, b), 32'(sampled), 32'(frame_of(b)));
      chk($sformatf("r%0d_outcome b=%0h", r, b), outcome, ack ? 2 : 1);
      chk($sformatf("r%0d_released", r), {busy, ps2_clk_drive_low, ps2_dat_drive_low}, 0);
    end

    repeat (5) @(negedge clk);
    chk("done_error_exclusive", both_cnt, 0);
    chk("pulse_width_one", wide_cnt, 0);
    chk("busy_low_with_done", busy_on_done, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
